bp_dma_mem_responder: RTL and testbench
=======================================

# bp_dma_mem_responder

Memory-side responder for the L2 cache DMA interface: accepts `bsg_cache_dma_pkt` requests from one CCE/L2 DMA channel and services them from an internal flop-array backing store. Reads stream a full L2 block back as fill-width beats; writes absorb a full block of beats under the packet's word mask. It terminates one `[cce][dma]` slice of the processor's DMA ports, for simulation and small-memory configurations.

## Interface
- `daddr_width_p`, 28: DMA address width.
- `l2_block_size_in_words_p`, 8: words per L2 block, and width of the packet mask.
- `word_width_p`, 64: word width in bits.
- `l2_fill_width_p`, 64: beat width. Must be a multiple of `word_width_p`.
- `mem_blocks_p`, 128: number of blocks in the backing store. Must be a power of 2.
- `delay_p`, 4: read stall in cycles. Used only under `BP_DMA_MEM_DELAY_EN`.
- Derived: `beats_lp = l2_block_size_in_words_p*word_width_p/l2_fill_width_p`; `wpb_lp = l2_fill_width_p/word_width_p`; `dma_pkt_width_lp = bsg_cache_dma_pkt_width(daddr_width_p, l2_block_size_in_words_p)`.

Ports:
- `clk_i` in 1: the single clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `dma_pkt_i` in `dma_pkt_width_lp`: request packet `{write_not_read, addr, mask}`.
- `dma_pkt_v_i` in 1: packet valid.
- `dma_pkt_ready_and_o` out 1: packet ready.
- `dma_data_i` in `l2_fill_width_p`: write-data beat.
- `dma_data_v_i` in 1: write-data valid.
- `dma_data_ready_and_o` out 1: write-data ready.
- `dma_data_o` out `l2_fill_width_p`: read-data beat.
- `dma_data_v_o` out 1: read-data valid.
- `dma_data_ready_and_i` in 1: read-data ready.

## Operation
- All three channels use ready-and-valid handshakes. A transfer occurs when `v & ready` in a cycle.
- States: `e_idle`, `e_delay` (only when the macro is defined), `e_read`, `e_write`.
- `e_idle`:
  - `dma_pkt_ready_and_o=1`.
  - On packet handshake, latch `blk = addr[log2(block bytes) +: log2(mem_blocks_p)]` and the mask, and clear the beat counter `cnt`.
  - Go to `e_write` if `write_not_read=1`; otherwise go to `e_read` (or `e_delay`).
  - Address bits below block alignment are ignored. Bits above the array index are ignored, so addresses wrap modulo `mem_blocks_p`.
- `e_read`:
  - `dma_data_v_o=1`, `dma_data_o = mem[blk][cnt]` (combinational array read).
  - Each handshake increments `cnt`. The handshake with `cnt==beats_lp-1` returns to `e_idle`.
- `e_write`:
  - `dma_data_ready_and_o=1`.
  - Each handshake writes word `w` of the beat to `mem[blk][cnt]` iff `mask[cnt*wpb_lp+w]`, then increments `cnt`.
  - The last beat returns to `e_idle`.
- Write data arriving in `e_idle` or `e_read` is not accepted (ready=0). The responder never reorders or overlaps transactions.
- Masked-off words keep their old contents. A write with all mask bits zero still consumes all `beats_lp` beats.
- Backing store has no reset; contents are undefined until written.
- `cnt` is `log2(beats_lp)` bits (minimum 1) and is compared against `beats_lp-1`; it never wraps mid-block.

## Timing
- Reset values: `dma_pkt_ready_and_o=0` while `reset_n_i=0`. State=`e_idle`, `cnt=0`, `dma_data_v_o=0`, `dma_data_ready_and_o=0`. `dma_data_o` is don't-care while not valid.
- `dma_pkt_ready_and_o` rises on the first clock edge after reset deassertion.
- Read latency without delay: packet handshake in cycle N gives the first beat valid in N+1. With zero backpressure, one beat per cycle, so the last beat is valid in N+`beats_lp`.
- Next packet is accepted in the cycle after the last data handshake (one idle bubble).
- `dma_data_o` is held stable while `v_o & ~ready_i`.
- Write is visible in the array on the edge of its handshake cycle. A read packet accepted the cycle after the write's last beat returns the new data.
- Reset asserted mid-transaction: the transaction is abandoned immediately. Beats already written remain; there is no further output activity.

## Configuration
- `BP_DMA_MEM_DELAY_EN`: when defined, a read packet enters `e_delay`, and a down-counter loaded with `delay_p` moves to `e_read` on reaching 0. First beat is valid in N+1+`delay_p`.
- During `e_delay` all outputs are valid=0 and ready=0.
- Writes are unaffected.
- Without the macro, `e_delay` and its counter are not compiled, and latency is as stated in Timing.

## Structure
- State enum `bp_dma_mem_state_e` lives in `bp_me_pkg`.
- Packet struct comes from the existing bsg_cache DMA packet declare macro; no new struct.
- One sub-module, `bp_dma_mem_array`: `mem_blocks_p*beats_lp` × `l2_fill_width_p` flop array, one async read port, one sync write port with per-word write enable.

## Test plan
- Write `addr=0x40`, mask=`0xFF`, beats 0x1..0x8, then read `0x40` → beats 0x1..0x8 in order; first beat valid 1 cycle after packet handshake.
- Write `0x40` with mask=`0x0F` and beats 0xA..0xH, then read → first four beats new, last four keep 0x5..0x8.
- Read with `dma_data_ready_and_i` toggling 1,0,0,1,… → `dma_data_o` stable across stalls; exactly 8 beats; then `dma_pkt_ready_and_o=1`.
- Wrap check: write block index `mem_blocks_p`, i.e. `addr = mem_blocks_p*64`, then read `addr=0` → same data.
- Drop `reset_n_i` during read beat 3 → `dma_data_v_o=0` immediately. After release: idle, `dma_pkt_ready_and_o=1`, and a new read works.
- `BP_DMA_MEM_DELAY_EN` with `delay_p=4`: first read beat valid exactly 5 cycles after packet handshake; write timing unchanged.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared types and sizing helpers for the BP memory-end DMA responder.
// The e_delay state exists only when BP_DMA_MEM_DELAY_EN is defined.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_read,
    e_write
`ifdef BP_DMA_MEM_DELAY_EN
    , e_delay
`endif
  } bp_dma_mem_state_e;

  // Packet layout is {write_not_read, addr, mask}, matching the bsg_cache DMA packet.
  function automatic int bsg_cache_dma_pkt_width(input int daddr_width,
                                                 input int block_size_in_words);
    return 1 + daddr_width + block_size_in_words;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_dma_mem_responder_if.sv
// DMA channel bundle between a CCE/L2 DMA port (master) and a memory responder (slave).
interface bp_dma_mem_responder_if
  import bp_me_pkg::*;
#(
  parameter int daddr_width_p            = 28,
  parameter int l2_block_size_in_words_p = 8,
  parameter int l2_fill_width_p          = 64
);

  localparam int dma_pkt_width_lp =
    bsg_cache_dma_pkt_width(daddr_width_p, l2_block_size_in_words_p);

  logic [dma_pkt_width_lp-1:0] dma_pkt_i;
  logic                        dma_pkt_v_i;
  logic                        dma_pkt_ready_and_o;
  logic [l2_fill_width_p-1:0]  dma_data_i;
  logic                        dma_data_v_i;
  logic                        dma_data_ready_and_o;
  logic [l2_fill_width_p-1:0]  dma_data_o;
  logic                        dma_data_v_o;
  logic                        dma_data_ready_and_i;

  modport master (
    output dma_pkt_i, dma_pkt_v_i,
    input  dma_pkt_ready_and_o,
    output dma_data_i, dma_data_v_i,
    input  dma_data_ready_and_o,
    input  dma_data_o, dma_data_v_o,
    output dma_data_ready_and_i
  );

  modport slave (
    input  dma_pkt_i, dma_pkt_v_i,
    output dma_pkt_ready_and_o,
    input  dma_data_i, dma_data_v_i,
    output dma_data_ready_and_o,
    output dma_data_o, dma_data_v_o,
    input  dma_data_ready_and_i
  );

endinterface

// File: rtl/bp_dma_mem_array.sv
// Flop-array backing store: one async read port, one sync write port with per-word enables.
// Contents are intentionally not reset.
module bp_dma_mem_array
  import bp_me_pkg::*;
#(
  parameter  int els_p         = 1024,
  parameter  int width_p       = 64,
  parameter  int word_width_p  = 64,
  localparam int words_lp      = width_p / word_width_p,
  localparam int addr_width_lp = clog2_min1(els_p)
) (
  input  logic                     clk_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [words_lp-1:0]      w_mask_i
);

  logic [width_p-1:0] mem_r [els_p];

  assign r_data_o = mem_r[r_addr_i];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      for (int unsigned w = 0; w < words_lp; w++) begin
        if (w_mask_i[w])
          mem_r[w_addr_i][w*word_width_p +: word_width_p] <= w_data_i[w*word_width_p +: word_width_p];
      end
    end
  end

endmodule

// File: rtl/bp_dma_mem_responder.sv
// Memory-side responder for one L2 DMA channel: streams whole blocks to/from a flop array.
// Optional read stall state compiled in with BP_DMA_MEM_DELAY_EN.
module bp_dma_mem_responder
  import bp_me_pkg::*;
#(
  parameter int daddr_width_p            = 28,
  parameter int l2_block_size_in_words_p = 8,
  parameter int word_width_p             = 64,
  parameter int l2_fill_width_p          = 64,
  parameter int mem_blocks_p             = 128,
  parameter int delay_p                  = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bp_dma_mem_responder_if.slave   dma
);

  localparam int beats_lp       = l2_block_size_in_words_p * word_width_p / l2_fill_width_p;
  localparam int wpb_lp         = l2_fill_width_p / word_width_p;
  localparam int block_bytes_lp = l2_block_size_in_words_p * word_width_p / 8;
  localparam int offset_w_lp    = $clog2(block_bytes_lp);
  localparam int blk_w_lp       = clog2_min1(mem_blocks_p);
  localparam int cnt_w_lp       = clog2_min1(beats_lp);
  localparam int idx_w_lp       = clog2_min1(mem_blocks_p * beats_lp);
  localparam int mask_w_lp      = l2_block_size_in_words_p;

  logic                     pkt_wnr;
  logic [daddr_width_p-1:0] pkt_addr;
  logic [mask_w_lp-1:0]     pkt_mask;

  assign {pkt_wnr, pkt_addr, pkt_mask} = dma.dma_pkt_i;

  bp_dma_mem_state_e state_r, state_n;
  logic                 live_r;
  logic [blk_w_lp-1:0]  blk_r;
  logic [mask_w_lp-1:0] mask_r;
  logic [cnt_w_lp-1:0]  cnt_r;

  logic pkt_ready, rd_v, wr_ready;
  logic pkt_hs, rd_hs, wr_hs, last_beat;

  assign last_beat = (cnt_r == cnt_w_lp'(beats_lp - 1));
  assign pkt_hs    = pkt_ready & dma.dma_pkt_v_i;
  assign rd_hs     = rd_v & dma.dma_data_ready_and_i;
  assign wr_hs     = wr_ready & dma.dma_data_v_i;

`ifdef BP_DMA_MEM_DELAY_EN
  localparam int dly_w_lp = clog2_min1(delay_p);
  logic [dly_w_lp-1:0] dly_r;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_idle;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n   = state_r;
    pkt_ready = 1'b0;
    rd_v      = 1'b0;
    wr_ready  = 1'b0;
    case (state_r)
      e_idle: begin
        // live_r holds ready low until the first edge after reset release
        pkt_ready = live_r;
        if (pkt_ready && dma.dma_pkt_v_i) begin
          if (pkt_wnr) state_n = e_write;
`ifdef BP_DMA_MEM_DELAY_EN
          else         state_n = (delay_p == 0) ? e_read : e_delay;
`else
          else         state_n = e_read;
`endif
        end
      end
`ifdef BP_DMA_MEM_DELAY_EN
      e_delay: begin
        if (dly_r == '0) state_n = e_read;
      end
`endif
      e_read: begin
        rd_v = 1'b1;
        if (dma.dma_data_ready_and_i && last_beat) state_n = e_idle;
      end
      e_write: begin
        wr_ready = 1'b1;
        if (dma.dma_data_v_i && last_beat) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      live_r <= 1'b0;
      blk_r  <= '0;
      mask_r <= '0;
      cnt_r  <= '0;
    end else begin
      live_r <= 1'b1;
      if (pkt_hs) begin
        blk_r  <= pkt_addr[offset_w_lp +: blk_w_lp];
        mask_r <= pkt_mask;
        cnt_r  <= '0;
      end else if (rd_hs || wr_hs) begin
        cnt_r  <= cnt_r + cnt_w_lp'(1);
      end
    end
  end

`ifdef BP_DMA_MEM_DELAY_EN
  // Loaded with delay_p-1 so e_delay lasts exactly delay_p cycles
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      dly_r <= '0;
    else if (pkt_hs)
      dly_r <= dly_w_lp'(delay_p - 1);
    else if ((state_r == e_delay) && (dly_r != '0))
      dly_r <= dly_r - dly_w_lp'(1);
  end
`endif

  logic [idx_w_lp-1:0]        mem_idx;
  logic [l2_fill_width_p-1:0] rd_data;
  logic [wpb_lp-1:0]          wr_mask;

  assign mem_idx = idx_w_lp'(blk_r) * idx_w_lp'(beats_lp) + idx_w_lp'(cnt_r);
  assign wr_mask = mask_r[int'(cnt_r)*wpb_lp +: wpb_lp];

  bp_dma_mem_array #(
    .els_p        (mem_blocks_p * beats_lp),
    .width_p      (l2_fill_width_p),
    .word_width_p (word_width_p)
  ) mem (
    .clk_i    (clk_i),
    .r_addr_i (mem_idx),
    .r_data_o (rd_data),
    .w_v_i    (wr_hs),
    .w_addr_i (mem_idx),
    .w_data_i (dma.dma_data_i),
    .w_mask_i (wr_mask)
  );

  assign dma.dma_pkt_ready_and_o  = pkt_ready;
  assign dma.dma_data_ready_and_o = wr_ready;
  assign dma.dma_data_v_o         = rd_v;
  assign dma.dma_data_o           = rd_data;

  // Offset and wrap-around address bits are deliberately ignored
  logic unused_ok;
  assign unused_ok = ^{pkt_addr, (delay_p != 0)};

endmodule

// File: tb/tb_bp_dma_mem_responder.sv
// Directed self-checking bench for bp_dma_mem_responder (default 8 x 64-bit beats per block).
module tb_bp_dma_mem_responder;

  localparam int DW = 28;
  localparam int BW = 8;
  localparam int FW = 64;
`ifdef BP_DMA_MEM_DELAY_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_dma_mem_responder_if #(
    .daddr_width_p            (DW),
    .l2_block_size_in_words_p (BW),
    .l2_fill_width_p          (FW)
  ) dma ();

  bp_dma_mem_responder #(
    .daddr_width_p            (DW),
    .l2_block_size_in_words_p (BW),
    .word_width_p             (64),
    .l2_fill_width_p          (FW),
    .mem_blocks_p             (128),
    .delay_p                  (4)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .dma       (dma)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the packet handshake.
  task automatic send_pkt(input logic wnr, input logic [DW-1:0] addr, input logic [BW-1:0] mask);
    int n;
    dma.dma_pkt_i   = {wnr, addr, mask};
    dma.dma_pkt_v_i = 1'b1;
    n = 0;
    while (dma.dma_pkt_ready_and_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_ready", 64'(dma.dma_pkt_ready_and_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    dma.dma_pkt_v_i = 1'b0;
  endtask

  task automatic write_blk(input logic [DW-1:0] addr, input logic [BW-1:0] mask,
                           input logic [63:0] d [8]);
    int n;
    send_pkt(1'b1, addr, mask);
    for (int k = 0; k < 8; k++) begin
      dma.dma_data_i   = d[k];
      dma.dma_data_v_i = 1'b1;
      n = 0;
      while (dma.dma_data_ready_and_o !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("wr_ready", 64'(dma.dma_data_ready_and_o), 64'd1);
      chk("wr_no_rd_valid", 64'(dma.dma_data_v_o), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    dma.dma_data_v_i = 1'b0;
    chk("wr_done_pkt_ready", 64'(dma.dma_pkt_ready_and_o), 64'd1);
    chk("wr_done_data_ready", 64'(dma.dma_data_ready_and_o), 64'd0);
  endtask

  // stall=1 drives ready_i as 1,0,0,1,0,0,...
  task automatic read_blk(input logic [DW-1:0] addr, input logic [63:0] exp [8], input bit stall);
    int n, k, cyc;
    logic rdy;
    send_pkt(1'b0, addr, '0);
    n = 1;
    while (dma.dma_data_v_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_latency", 64'(n), 64'(LAT));
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 100) begin
      rdy = stall ? (cyc % 3 == 0) : 1'b1;
      dma.dma_data_ready_and_i = rdy;
      chk("rd_valid", 64'(dma.dma_data_v_o), 64'd1);
      chk("rd_data", dma.dma_data_o, exp[k]);
      chk("rd_no_wr_ready", 64'(dma.dma_data_ready_and_o), 64'd0);
      @(posedge clk);
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    dma.dma_data_ready_and_i = 1'b0;
    chk("rd_beats", 64'(k), 64'd8);
    chk("rd_done_valid", 64'(dma.dma_data_v_o), 64'd0);
    chk("rd_done_pkt_ready", 64'(dma.dma_pkt_ready_and_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d1 [8];
    logic [63:0] d2 [8];
    logic [63:0] m2 [8];
    logic [63:0] dz [8];
    logic [63:0] dw [8];
    for (int i = 0; i < 8; i++) begin
      d1[i] = 64'(i + 1);
      d2[i] = 64'h0A0 + 64'(i);
      m2[i] = (i < 4) ? d2[i] : d1[i];
      dz[i] = 64'hDEAD_0000 + 64'(i);
      dw[i] = 64'h100 + 64'(i);
    end

    dma.dma_pkt_i            = '0;
    dma.dma_pkt_v_i          = 1'b0;
    dma.dma_data_i           = '0;
    dma.dma_data_v_i         = 1'b0;
    dma.dma_data_ready_and_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pkt_ready", 64'(dma.dma_pkt_ready_and_o), 64'd0);
    chk("rst_data_v", 64'(dma.dma_data_v_o), 64'd0);
    chk("rst_data_ready", 64'(dma.dma_data_ready_and_o), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_pkt_ready_before_edge", 64'(dma.dma_pkt_ready_and_o), 64'd0);
    @(negedge clk);
    chk("rel_pkt_ready_after_edge", 64'(dma.dma_pkt_ready_and_o), 64'd1);

    // Full write then read back
    write_blk(28'h40, 8'hFF, d1);
    read_blk(28'h40, d1, 1'b0);

    // Partial mask: low four beats replaced
    write_blk(28'h40, 8'h0F, d2);
    read_blk(28'h40, m2, 1'b0);

    // All-zero mask consumes the block without changing it
    write_blk(28'h40, 8'h00, dz);
    read_blk(28'h40, m2, 1'b0);

    // Backpressure on the read channel
    read_blk(28'h40, m2, 1'b1);

    // Block index mem_blocks_p wraps to block 0; low offset bits ignored
    write_blk(28'h2000, 8'hFF, dw);
    read_blk(28'h0, dw, 1'b0);
    read_blk(28'h3F, dw, 1'b0);

    // Reset during read beat 3
    send_pkt(1'b0, 28'h40, '0);
    begin
      int n;
      n = 1;
      while (dma.dma_data_v_o !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("mid_rst_latency", 64'(n), 64'(LAT));
    end
    dma.dma_data_ready_and_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_pre_data", dma.dma_data_o, m2[k]);
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_rst_beat3", dma.dma_data_o, m2[3]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v_now", 64'(dma.dma_data_v_o), 64'd0);
    chk("mid_rst_pkt_ready", 64'(dma.dma_pkt_ready_and_o), 64'd0);
    @(negedge clk);
    chk("mid_rst_v_held", 64'(dma.dma_data_v_o), 64'd0);
    dma.dma_data_ready_and_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_pkt_ready", 64'(dma.dma_pkt_ready_and_o), 64'd1);
    chk("post_rst_data_v", 64'(dma.dma_data_v_o), 64'd0);
    read_blk(28'h40, m2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
